// File: rtl/booth_radix4_seq_mult_if.sv
// Operand/result handshake bundle for the radix-4 Booth sequential multiplier.
interface booth_radix4_seq_mult_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      i_valid;
    logic [DATA_WIDTH-1:0]     i_multiplicand;
    logic [DATA_WIDTH-1:0]     i_multiplier;
    logic                      o_ready;
    logic                      o_valid;
    logic [2*DATA_WIDTH-1:0]   o_product;
    logic                      o_busy;

    // Producer side: drives operands, observes status and result.
    modport master (
        output i_valid,
        output i_multiplicand,
        output i_multiplier,
        input  o_ready,
        input  o_valid,
        input  o_product,
        input  o_busy
    );

    // Multiplier side.
    modport slave (
        input  i_valid,
        input  i_multiplicand,
        input  i_multiplier,
        output o_ready,
        output o_valid,
        output o_product,
        output o_busy
    );
endinterface

// File: rtl/booth_radix4_seq_mult.sv
// Sequential signed radix-4 (modified Booth) multiplier with a carry-lookahead
// accumulator. One Booth digit is retired per clock; the final sum is
// published for a single o_valid cycle.

// Parallel-prefix (Kogge-Stone) carry-lookahead adder, no carry-in.
module CLA_adder #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);
    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] half_sum;
    logic [WIDTH-1:0] gen_c;
    logic [WIDTH-1:0] prop_c;

    assign half_sum = i_a ^ i_b;

    // Prefix tree: after the last level gen_c[i] is the carry out of bit i.
    always_comb begin
        gen_c  = i_a & i_b;
        prop_c = i_a ^ i_b;
        for (int lv = 0; lv < int'(LEVELS); lv++) begin
            gen_c  = gen_c | (prop_c & (gen_c << (1 << lv)));
            prop_c = prop_c & ((prop_c << (1 << lv)) | ~(ONES << (1 << lv)));
        end
    end

    assign o_sum   = half_sum ^ {gen_c[WIDTH-2:0], 1'b0};
    assign o_carry = gen_c[WIDTH-1];
endmodule

module booth_radix4_seq_mult #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic i_clk,
    input  logic i_rst,
    booth_radix4_seq_mult_if.slave bus
);
    localparam int unsigned ITER = DATA_WIDTH / 2;
    localparam int unsigned PW   = 2 * DATA_WIDTH;
    localparam int unsigned CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic accept_c;
    logic step_c;
    logic finish_c;

    logic [PW-1:0]         mcand_q;
    logic [DATA_WIDTH-1:0] mplier_q;
    logic                  yhist_q;
    logic [PW-1:0]         acc_q;
    logic [CW-1:0]         cnt_q;

    logic [2:0]            booth_sel_c;
    logic [PW-1:0]         pp_mag_c;
    logic                  pp_neg_c;
    logic [PW-1:0]         pp_c;
    logic [PW-1:0]         sum_c;
    logic                  carry_unused;

    logic                  ready_q;
    logic                  valid_q;
    logic                  busy_q;
    logic [PW-1:0]         product_q;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and control strobes. RUN spends one extra cycle after the
    // last digit so the product is taken straight from the settled accumulator.
    always_comb begin
        state_nxt = state_q;
        accept_c  = 1'b0;
        step_c    = 1'b0;
        finish_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    accept_c  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CW'(ITER)) begin
                    finish_c  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    step_c = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Booth digit decode from the two low multiplier bits plus history bit.
    always_comb begin
        booth_sel_c = {mplier_q[1], mplier_q[0], yhist_q};
        pp_mag_c    = '0;
        pp_neg_c    = 1'b0;
        unique case (booth_sel_c)
            3'b001, 3'b010: pp_mag_c = mcand_q;
            3'b011:         pp_mag_c = mcand_q << 1;
            3'b100: begin
                pp_mag_c = mcand_q << 1;
                pp_neg_c = 1'b1;
            end
            3'b101, 3'b110: begin
                pp_mag_c = mcand_q;
                pp_neg_c = 1'b1;
            end
            default: begin
                pp_mag_c = '0;
                pp_neg_c = 1'b0;
            end
        endcase
    end

    // Negate at full width so -2M is exact even for the most-negative M.
    assign pp_c = pp_neg_c ? (~pp_mag_c + PW'(1)) : pp_mag_c;

    CLA_adder #(
        .WIDTH (PW)
    ) u_cla (
        .i_a     (acc_q),
        .i_b     (pp_c),
        .o_sum   (sum_c),
        .o_carry (carry_unused)
    );

    // Operand latch and per-digit accumulate; multiplicand pre-shifted by 2 each step.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            yhist_q  <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (accept_c) begin
            mcand_q  <= {{DATA_WIDTH{bus.i_multiplicand[DATA_WIDTH-1]}}, bus.i_multiplicand};
            mplier_q <= bus.i_multiplier;
            yhist_q  <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step_c) begin
            mcand_q  <= mcand_q << 2;
            mplier_q <= mplier_q >> 2;
            yhist_q  <= mplier_q[1];
            acc_q    <= sum_c;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

    // Registered status and result outputs, decoded from the upcoming state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            product_q <= '0;
        end else begin
            ready_q <= (state_nxt == IDLE);
            valid_q <= (state_nxt == DONE);
            busy_q  <= (state_nxt != IDLE);
            if (finish_c) begin
                product_q <= acc_q;
            end
        end
    end

    assign bus.o_ready   = ready_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_product = product_q;
endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Scoreboard bench for booth_radix4_seq_mult: directed corner cases plus
// randomized signed operands against a plain-arithmetic reference product.
module tb_booth_radix4_seq_mult;
    localparam int unsigned DW  = 32;
    localparam int unsigned PW  = 64;
    localparam int          LAT = 17;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    booth_radix4_seq_mult_if #(.DATA_WIDTH(DW)) bus ();

    booth_radix4_seq_mult #(.DATA_WIDTH(DW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [PW-1:0] exp_q[$];
    int            due_q[$];
    int            pulse_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact signed product of the two operands.
    function automatic logic [PW-1:0] ref_mul(input logic [DW-1:0] m, input logic [DW-1:0] y);
        longint a;
        longint b;
        a = longint'($signed(m));
        b = longint'($signed(y));
        return PW'(a * b);
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] pick_operand();
        int r;
        r = int'($urandom_range(0, 9));
        case (r)
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Result monitor: every o_valid pulse pops one scoreboard entry.
    always @(negedge clk) begin : monitor
        logic [PW-1:0] e;
        int            d;
        if (bus.o_valid === 1'b1) begin
            pulse_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", PW'(bus.o_valid), PW'(0));
            end else begin
                e = exp_q.pop_front();
                d = due_q.pop_front();
                check("product", bus.o_product, e);
                check("latency", PW'(cyc), PW'(d));
                check("ready_in_done", PW'(bus.o_ready), PW'(0));
            end
        end
    end

    // Present operands at a falling edge and hold until accepted; returns at
    // the falling edge right after the accept edge.
    task automatic issue(input logic [DW-1:0] m, input logic [DW-1:0] y,
                         input bit keep_valid, input logic [PW-1:0] exp);
        int guard;
        guard = 0;
        bus.i_valid        = 1'b1;
        bus.i_multiplicand = m;
        bus.i_multiplier   = y;
        while (bus.o_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            check("accept_timeout", PW'(bus.o_ready), PW'(1));
        end
        @(posedge clk);
        @(negedge clk);
        exp_q.push_back(exp);
        due_q.push_back(cyc + LAT);
        if (!keep_valid) bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", PW'(exp_q.size()), PW'(0));
            exp_q.delete();
            due_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   PW'(bus.o_ready),   PW'(1));
        check({tag, "_valid"},   PW'(bus.o_valid),   PW'(0));
        check({tag, "_busy"},    PW'(bus.o_busy),    PW'(0));
        check({tag, "_product"}, bus.o_product,      PW'(0));
    endtask

    logic [DW-1:0] dir_m [5];
    logic [DW-1:0] dir_y [5];
    logic [PW-1:0] dir_p [5];

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin : stimulus
        logic [DW-1:0] m;
        logic [DW-1:0] y;
        bit            keep;

        dir_m[0] = 32'hFFFF_FFFF; dir_y[0] = 32'hFFFF_FFFF; dir_p[0] = 64'h0000_0000_0000_0001;
        dir_m[1] = 32'hFFFF_FFFF; dir_y[1] = 32'h7FFF_FFFF; dir_p[1] = 64'hFFFF_FFFF_8000_0001;
        dir_m[2] = 32'h8000_0000; dir_y[2] = 32'h8000_0000; dir_p[2] = 64'h4000_0000_0000_0000;
        dir_m[3] = 32'h7FFF_FFFF; dir_y[3] = 32'h8000_0000; dir_p[3] = 64'hC000_0000_8000_0000;
        dir_m[4] = 32'h1023_AC52; dir_y[4] = 32'h0000_0000; dir_p[4] = 64'h0;

        rst                = 1'b1;
        bus.i_valid        = 1'b0;
        bus.i_multiplicand = '0;
        bus.i_multiplier   = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic: latency and ready/busy across the whole operation.
        issue(32'd5, 32'd3, 1'b0, 64'h0000_0000_0000_000F);
        for (int k = 0; k < LAT; k++) begin
            check("basic_ready_low", PW'(bus.o_ready), PW'(0));
            check("basic_busy_high", PW'(bus.o_busy),  PW'(1));
            @(negedge clk);
        end
        drain();

        // Sign and extreme-value cases.
        for (int i = 0; i < 5; i++) begin
            issue(dir_m[i], dir_y[i], 1'b0, dir_p[i]);
            drain();
        end

        // Back-to-back with operand churn while running.
        pulse_q.delete();
        issue(32'd5, 32'd10, 1'b1, 64'h32);
        repeat (5) begin
            bus.i_multiplicand = $urandom;
            bus.i_multiplier   = $urandom;
            @(negedge clk);
        end
        issue(32'd12, 32'hFFFF_FFFD, 1'b0, 64'hFFFF_FFFF_FFFF_FFDC);
        repeat (5) begin
            bus.i_multiplicand = $urandom;
            bus.i_multiplier   = $urandom;
            @(negedge clk);
        end
        drain();
        if (pulse_q.size() >= 2) begin
            check("b2b_gap", PW'(pulse_q[1] - pulse_q[0]), PW'(19));
        end else begin
            check("b2b_pulses", PW'(pulse_q.size()), PW'(2));
        end

        // Reset abort mid-run.
        issue(32'd7, 32'd9, 1'b0, ref_mul(32'd7, 32'd9));
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        due_q.delete();
        check_reset_outputs("abort");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("abort_held");
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check("abort_idle_ready", PW'(bus.o_ready), PW'(1));
        issue(32'd2, 32'd3, 1'b0, 64'h6);
        drain();

        // Randomized signed operands, mixing back-to-back and idle gaps.
        for (int i = 0; i < 1000; i++) begin
            m    = pick_operand();
            y    = pick_operand();
            keep = (i < 999) ? 1'($urandom_range(0, 1)) : 1'b0;
            issue(m, y, keep, ref_mul(m, y));
            if (!keep) begin
                repeat (int'($urandom_range(0, 2))) begin
                    bus.i_multiplicand = $urandom;
                    bus.i_multiplier   = $urandom;
                    @(negedge clk);
                end
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
